// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - exception detect, EPC save and vector fetch sequencer
//
// Purpose: sits directly upstream of the EPC register in a multicycle MIPS
// datapath. It resolves exception priority, writes the faulting PC into EPC,
// reads the handler vector byte from memory and loads it into PC. It holds
// busy for the whole sequence so the main control unit stalls.
//
// Ports:
//   clk                   rising-edge system clock
//   reset                 asynchronous active-low reset
//   flag_opcode/ovf/div0  exception flags, level-sensitive
//   pc_cur                address of the faulting instruction
//   mem_rdata             vector byte returned by memory
//   epc_we, epc_data      one-cycle EPC write of the latched PC
//   mem_rd, mem_addr      vector byte read request
//   pc_we, pc_next        one-cycle PC write of the zero-extended vector byte
//   busy                  high in SAVE, FETCH and LOAD
//   cause                 latched cause: 0 none, 1 opcode, 2 ovf, 3 div0
//   nested                sticky: an exception arrived while not idle
module exception_sequencer #(
    parameter int VEC_BASE = 253,
    parameter int MEM_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flag_opcode,
    input  logic        flag_ovf,
    input  logic        flag_div0,
    input  logic [31:0] pc_cur,
    input  logic [7:0]  mem_rdata,
    output logic        epc_we,
    output logic [31:0] epc_data,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic        busy,
    output logic [1:0]  cause,
    output logic        nested
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_FETCH,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [2:0]  LAT_LAST   = 3'(MEM_LAT - 1);
    localparam logic [31:0] VEC_BASE_W = 32'(VEC_BASE);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cause;
    logic [31:0] r_pc;
    logic [7:0]  r_byte;
    logic [2:0]  r_cnt;
    logic        r_nested;

    logic        w_any;
    logic [1:0]  w_cause;
    logic        w_fetch_last;

    assign w_any        = flag_opcode | flag_ovf | flag_div0;
    assign w_cause      = flag_opcode ? 2'd1 :
                          flag_ovf    ? 2'd2 :
                          flag_div0   ? 2'd3 : 2'd0;
    assign w_fetch_last = (r_cnt == LAT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cause  <= 2'd0;
            r_pc     <= 32'd0;
            r_byte   <= 8'd0;
            r_cnt    <= 3'd0;
            r_nested <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any flag outside IDLE (DONE included) is dropped but remembered.
            if (r_state != S_IDLE && w_any)
                r_nested <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cause <= w_cause;
                        r_pc    <= pc_cur;
                    end
                end
                S_SAVE:  r_cnt <= 3'd0;
                S_FETCH: begin
                    r_cnt <= r_cnt + 3'd1;
                    // Memory data is valid at the edge that leaves FETCH.
                    if (w_fetch_last)
                        r_byte <= mem_rdata;
                end
                // Clear on entry to DONE so cause reads 0 during DONE.
                S_LOAD:  r_cause <= 2'd0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        epc_we   = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = 32'd0;
        pc_we    = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any)
                    w_next = S_SAVE;
            end
            S_SAVE: begin
                epc_we = 1'b1;
                busy   = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = VEC_BASE_W + {30'd0, r_cause} - 32'd1;
                busy     = 1'b1;
                if (w_fetch_last)
                    w_next = S_LOAD;
            end
            S_LOAD: begin
                pc_we  = 1'b1;
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign epc_data = r_pc;
    assign pc_next  = {24'd0, r_byte};
    assign cause    = r_cause;
    assign nested   = r_nested;

endmodule
